// File: rtl/bpsk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bpsk_pkg
//  Description : Shared types and helpers for the BPSK correlator datapath.
//                Holds the window state type used by the serial window summer
//                and the sum-width helper shared with the parallel reducer.
//  Revision    : 1.0 - initial release
// ============================================================================
package bpsk_pkg;

    // Window state: FILL until N samples have been seen, then RUN.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } win_state_t;

    // Width needed to hold the sum of n unsigned w-bit values.
    function automatic int sum_width(input int n, input int w);
        return w + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : sample_delay_line
//  Description : N-entry circular sample buffer. dout_oldest presents the
//                entry at the write pointer, i.e. the sample that the next push
//                overwrites (read-before-write). N need not be a power of two.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                clear           - synchronous write-pointer reset (contents kept)
//                push            - write din and advance the pointer
//                din             - sample to store
//                dout_oldest     - sample that the next push evicts
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_delay_line #(
    parameter int N        = 8,
    parameter int WIDTH_IN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                push,
    input  logic [WIDTH_IN-1:0] din,
    output logic [WIDTH_IN-1:0] dout_oldest
);

    localparam int PTR_W = $clog2(N);

    logic [WIDTH_IN-1:0] r_mem [N];
    logic [PTR_W-1:0]    r_wptr;

    assign dout_oldest = r_mem[r_wptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            // Stale contents stay; the owner masks them while refilling.
            r_wptr <= '0;
        end else if (push) begin
            r_mem[r_wptr] <= din;
            r_wptr        <= (r_wptr == PTR_W'(N - 1)) ? '0 : r_wptr + PTR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sliding_window_sum.sv
`default_nettype none
// ============================================================================
//  Module      : sliding_window_sum
//  Description : Running sum of the last N accepted unsigned samples. Each
//                accepted sample is added and the evicted sample subtracted,
//                so cost does not depend on N. Output is registered (latency 1)
//                with a valid/ready handshake.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                flush           - synchronous window clear (wins over accept)
//                in_valid/in_ready/in_data    - sample input handshake
//                out_valid/out_ready/out_data - window sum output handshake
//  Build macro : SLIDING_WINDOW_PARTIAL_OUT_EN - when defined, also emit the
//                partial sum on every accept while the window is filling.
//  Revision    : 1.0 - initial release
// ============================================================================
module sliding_window_sum
    import bpsk_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int WIDTH_IN = 1,
    localparam int SUM_W    = sum_width(N, WIDTH_IN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH_IN-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SUM_W-1:0]    out_data
);

`ifdef SLIDING_WINDOW_PARTIAL_OUT_EN
    localparam bit C_PARTIAL = 1'b1;
`else
    localparam bit C_PARTIAL = 1'b0;
`endif

    localparam int CNT_W = $clog2(N + 1);

    win_state_t          r_state;
    win_state_t          w_state_d;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_d;
    logic [SUM_W-1:0]    r_sum;
    logic [SUM_W-1:0]    w_sum_d;
    logic                r_out_valid;
    logic                w_out_valid_d;
    logic                w_accept;
    logic                w_push;
    logic [WIDTH_IN-1:0] w_oldest;

    // Only combinational path in the block: out_ready -> in_ready.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    // A flush in the same cycle drops the sample.
    assign w_push    = w_accept && !flush;
    assign out_valid = r_out_valid;
    assign out_data  = r_sum;

    sample_delay_line #(
        .N        (N),
        .WIDTH_IN (WIDTH_IN)
    ) u_delay (
        .clk         (clk),
        .rst         (rst),
        .clear       (flush),
        .push        (w_push),
        .din         (in_data),
        .dout_oldest (w_oldest)
    );

    always_comb begin
        w_state_d     = r_state;
        w_count_d     = r_count;
        w_sum_d       = r_sum;
        w_out_valid_d = r_out_valid;

        if (flush) begin
            w_state_d     = FILL;
            w_count_d     = '0;
            w_sum_d       = '0;
            w_out_valid_d = 1'b0;
        end else if (w_accept) begin
            // While filling, the slot being overwritten holds either reset
            // zeros or pre-flush data, so eviction is masked.
            w_sum_d = r_sum + SUM_W'(in_data)
                    - ((r_state == RUN) ? SUM_W'(w_oldest) : SUM_W'(0));
            if (r_state == FILL) begin
                w_count_d = r_count + CNT_W'(1);
                if (r_count == CNT_W'(N - 1)) begin
                    w_state_d     = RUN;
                    w_out_valid_d = 1'b1;
                end else begin
                    w_out_valid_d = C_PARTIAL;
                end
            end else begin
                w_out_valid_d = 1'b1;
            end
        end else if (out_ready) begin
            w_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FILL;
            r_count     <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_count     <= w_count_d;
            r_sum       <= w_sum_d;
            r_out_valid <= w_out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sliding_window_sum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sliding_window_sum
//  Description : Self-checking bench for sliding_window_sum. Two instances
//                (N=8/WIDTH_IN=1 and N=3/WIDTH_IN=3) are driven with directed
//                and random traffic; a window-of-samples reference model
//                queues expected sums and a monitor checks each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sliding_window_sum;

`ifdef SLIDING_WINDOW_PARTIAL_OUT_EN
    localparam bit PARTIAL = 1'b1;
`else
    localparam bit PARTIAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv0 = 0, fl0 = 0, or0 = 0;
    logic [0:0] d0  = '0;
    logic       ov0, ir0;
    logic [3:0] od0;
    logic       iv1 = 0, fl1 = 0, or1 = 0;
    logic [2:0] d1  = '0;
    logic       ov1, ir1;
    logic [4:0] od1;

    sliding_window_sum #(.N(8), .WIDTH_IN(1)) dut0 (
        .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
        .in_data(d0), .out_valid(ov0), .out_ready(or0), .out_data(od0));

    sliding_window_sum #(.N(3), .WIDTH_IN(3)) dut1 (
        .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
        .in_data(d1), .out_valid(ov1), .out_ready(or1), .out_data(od1));

    int n_pass   = 0;
    int n_checks = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // ---- per-instance accessors ----
    function automatic int n_win(int k);   return (k == 0) ? 8 : 3;   endfunction
    function automatic int max_sum(int k); return (k == 0) ? 15 : 31; endfunction
    function automatic int dut_ov(int k);  return (k == 0) ? int'(ov0) : int'(ov1); endfunction
    function automatic int dut_ir(int k);  return (k == 0) ? int'(ir0) : int'(ir1); endfunction
    function automatic int dut_od(int k);  return (k == 0) ? int'(od0) : int'(od1); endfunction
    function automatic bit in_v(int k);    return (k == 0) ? iv0 : iv1; endfunction
    function automatic bit in_f(int k);    return (k == 0) ? fl0 : fl1; endfunction
    function automatic bit in_r(int k);    return (k == 0) ? or0 : or1; endfunction
    function automatic int in_d(int k);    return (k == 0) ? int'(d0) : int'(d1); endfunction

    // ---- reference model: accepted-sample history and expected outputs ----
    int h0[$], h1[$];
    int q0[$], q1[$];
    bit ovm[2];
    int nacc[2];
    int epoch = 0;

    function automatic void hist_push(int k, int v);
        if (k == 0) begin h0.push_back(v); if (h0.size() > 8) void'(h0.pop_front()); end
        else        begin h1.push_back(v); if (h1.size() > 3) void'(h1.pop_front()); end
    endfunction

    function automatic int hist_sum(int k);
        int s = 0;
        if (k == 0) foreach (h0[i]) s += h0[i];
        else        foreach (h1[i]) s += h1[i];
        return s;
    endfunction

    function automatic void hist_clear(int k);
        if (k == 0) h0.delete(); else h1.delete();
    endfunction

    function automatic void sb_push(int k, int v);
        if (k == 0) q0.push_back(v); else q1.push_back(v);
    endfunction
    function automatic int sb_size(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction
    function automatic int sb_pop(int k);
        return (k == 0) ? q0.pop_front() : q1.pop_front();
    endfunction
    function automatic void sb_drop_last(int k);
        if (k == 0) begin if (q0.size() > 0) void'(q0.pop_back()); end
        else        begin if (q1.size() > 0) void'(q1.pop_back()); end
    endfunction

    function automatic void model_reset();
        h0.delete(); h1.delete(); q0.delete(); q1.delete();
        for (int k = 0; k < 2; k++) begin ovm[k] = 0; nacc[k] = 0; end
        epoch++;
    endfunction

    // Evaluates the inputs presented for the coming edge.
    function automatic void model_step(int k);
        int  exp_ir;
        bit  acc;
        int  s;
        exp_ir = (!ovm[k] || in_r(k)) ? 1 : 0;
        check($sformatf("in_ready[%0d]", k), dut_ir(k), exp_ir);
        check($sformatf("out_valid[%0d]", k), dut_ov(k), int'(ovm[k]));
        acc = in_v(k) && (exp_ir != 0);
        if (in_f(k)) begin
            if (ovm[k] && !in_r(k)) sb_drop_last(k);   // pending output lost
            hist_clear(k);
            nacc[k] = 0;
            ovm[k]  = 0;
        end else if (acc) begin
            hist_push(k, in_d(k));
            nacc[k]++;
            if (nacc[k] >= n_win(k) || PARTIAL) begin
                s = hist_sum(k);
                check($sformatf("no_overflow[%0d]", k), int'(s <= max_sum(k)), 1);
                sb_push(k, s);
                ovm[k] = 1;
            end
        end else if (in_r(k)) begin
            ovm[k] = 0;
        end
    endfunction

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            model_step(0);
            model_step(1);
        end
    end

    // ---- monitor: pops an expectation whenever an output is consumed ----
    bit stall[2];
    int pdata[2];
    int pep[2];

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (dut_ov(k) != 0) begin
                    if (stall[k] && pep[k] == epoch)
                        check($sformatf("hold_data[%0d]", k), dut_od(k), pdata[k]);
                    if (in_r(k)) begin
                        if (sb_size(k) == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_output[%0d]: got %0d, expected no output",
                                     k, dut_od(k));
                        end else begin
                            check($sformatf("out_data[%0d]", k), dut_od(k), sb_pop(k));
                        end
                    end
                end
                stall[k] = (dut_ov(k) != 0) && !in_r(k);
                pdata[k] = dut_od(k);
                pep[k]   = epoch;
            end
        end
    end

    // ---- stimulus ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(int k, bit v, int d, bit f, bit r);
        if (k == 0) begin iv0 = v; d0 = d[0:0]; fl0 = f; or0 = r; end
        else        begin iv1 = v; d1 = d[2:0]; fl1 = f; or1 = r; end
    endtask

    task automatic run(int k, bit v, int d, bit f, bit r, int cycles);
        for (int i = 0; i < cycles; i++) begin
            set_in(k, v, d, f, r);
            tick();
        end
    endtask

    initial begin
        int seq_b[5] = '{7, 7, 7, 1, 0};
        model_reset();
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_out_valid[%0d]", k), dut_ov(k), 0);
            check($sformatf("rst_in_ready[%0d]", k), dut_ir(k), 1);
            check($sformatf("rst_out_data[%0d]", k), dut_od(k), 0);
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0, 1);
        set_in(1, 0, 0, 0, 1);
        tick();

        // Fill with eight ones, then two zeros: 8, 7, 6.
        run(0, 1, 1, 0, 1, 8);
        run(0, 1, 0, 0, 1, 2);
        run(0, 0, 0, 0, 1, 3);

        // Backpressure: one output held for several cycles with input pending.
        run(0, 1, 1, 0, 1, 1);
        run(0, 1, 0, 0, 0, 6);
        run(0, 1, 1, 0, 1, 6);
        run(0, 0, 0, 0, 1, 2);

        // Flush with a same-cycle sample, then refill with ones.
        run(0, 1, 1, 1, 1, 1);
        run(0, 1, 1, 0, 1, 8);
        run(0, 0, 0, 0, 1, 2);

        // Asynchronous reset while an output is held.
        run(0, 1, 0, 0, 0, 1);
        set_in(0, 0, 0, 0, 0);
        tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", int'(ov0), 0);
        check("async_rst_in_ready", int'(ir0), 1);
        check("async_rst_out_data", int'(od0), 0);
        rst = 1'b0;
        model_reset();
        run(0, 1, 1, 0, 1, 8);
        run(0, 0, 0, 0, 1, 2);

        // N=3 window at full-scale input: 21, 15, 8.
        for (int i = 0; i < 5; i++) run(1, 1, seq_b[i], 0, 1, 1);
        run(1, 0, 0, 0, 1, 2);

        // Random traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++)
                set_in(k, $urandom_range(0, 3) != 0,
                       int'($urandom_range(0, (k == 0) ? 1 : 7)),
                       $urandom_range(0, 39) == 0,
                       $urandom_range(0, 3) != 0);
            tick();
        end

        // Drain and confirm every expected output was seen.
        set_in(0, 0, 0, 0, 1);
        set_in(1, 0, 0, 0, 1);
        repeat (4) tick();
        check("sb_empty[0]", q0.size(), 0);
        check("sb_empty[1]", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sliding_window_sum.md
Name: sliding_window_sum

Overview:
- Serial counterpart of the parallel N-input reducer.
- Accepts one WIDTH_IN-bit unsigned sample per handshake and keeps the running sum of the last N accepted samples.
- Each new sample adds itself and subtracts the sample it evicts, so the cost is independent of N.
- Used as the BPSK correlator/moving-average stage when samples arrive serially rather than as a parallel vector.

Parameters:
- N, 8, window length in samples; legal range 2..1024.
- WIDTH_IN, 1, unsigned sample width.
- SUM_W, WIDTH_IN + $clog2(N), output width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous window clear.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH_IN  unsigned sample.
- out_valid  output  1  out_data holds a valid window sum.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  SUM_W  sum of the last N accepted samples.

Behaviour:
- Reset values: all outputs 0 except in_ready = 1; sum, fill count, write pointer and all buffer entries are 0; state = FILL.
- Accept rule: a sample is taken when in_valid && in_ready, where in_ready = !out_valid || out_ready. in_ready is combinational from out_ready; there is no other combinational path.
- Buffer:
  - N-entry circular buffer, write pointer 0..N-1, wraps from N-1 to 0. N need not be a power of two.
  - On accept: oldest = buf[wptr]; buf[wptr] <= in_data; wptr advances.
- Arithmetic:
  - sum_next = sum + in_data - (state==RUN ? oldest : 0), computed in SUM_W bits.
  - The result can never overflow or underflow; the bench asserts this.
- State machine:
  - FILL: fill count increments on each accept. On the accept that brings the count to N, go to RUN.
  - RUN: stays in RUN on every accept; fill count holds at N. Leaves RUN only on flush or rst.
- Output:
  - Registered, latency 1: out_data/out_valid update the cycle after the accept.
  - out_valid is set on any accept in RUN, and on the accept that completes FILL.
  - out_valid is cleared when out_ready && !accept.
  - While out_valid && !out_ready, out_data and out_valid hold stable and in_ready = 0.
- Flush:
  - Next edge: sum = 0, count = 0, wptr = 0, state = FILL, out_valid = 0. Buffer contents are not cleared; the FILL gating masks them.
  - flush && accept in the same cycle: flush wins and the sample is dropped.
- rst asserted mid-stream: immediate asynchronous return to reset values; any pending output is lost.

Optional Feature:
- Macro: SLIDING_WINDOW_PARTIAL_OUT_EN.
- Defined: out_valid is also produced for every accept during FILL, carrying the partial sum of the samples so far. Each output is the sum of min(count, N) samples.
- Undefined: no outputs until the window is full, as described in Behaviour.

Decomposition:
- Shared package bpsk_pkg holds:
  - typedef enum logic {FILL, RUN} win_state_t;
  - function sum_width(n, w), returning w + $clog2(n), also used by the parallel reducer.
- One natural sub-module, sample_delay_line (parameters N, WIDTH_IN):
  - Owns the circular buffer and wptr.
  - Inputs: push, din. Output: dout_oldest, read before the write.

Test Plan:
- N=8, WIDTH_IN=1, out_ready=1, eight samples of 1 back-to-back:
  - no out_valid during the first seven;
  - out_data=8 one cycle after the 8th accept;
  - then feed 0,0 → outputs 7, 6.
- N=3, WIDTH_IN=3, feed 7,7,7,1,0: outputs 21 (max, no overflow), then 15, then 8; exercises wrap at N not a power of 2.
- Backpressure, N=8: hold out_ready=0 with out_valid=1 for 5 cycles while in_valid=1:
  - in_ready=0 and out_data stable throughout;
  - on release, exactly one output is consumed per accept and no samples are lost.
- Flush in RUN with the same-cycle in_valid=1, data=1:
  - sample dropped, out_valid=0 next cycle;
  - the next 8 samples of 1 yield first output 8, proving the stale buffer is masked.
- rst pulsed asynchronously mid-window (between clock edges):
  - outputs go to reset values immediately;
  - refill behaves as from power-up.
- With SLIDING_WINDOW_PARTIAL_OUT_EN, N=4, feed 1,2,3,4,5 with WIDTH_IN=3 → outputs 1, 3, 6, 10, 14.
